vending_fsm_param: RTL and testbench

Parametrised coin-operated vending controller. Accepts one coin per cycle in three configurable denominations and vends when accumulated credit reaches PRICE. Returns change, or a full refund on cancel, as a sequence of single-coin pulses, greedy largest-first. Sits between the debounced coin/cancel inputs and the dispenser/change-hopper drivers.

---
 rtl/vending_fsm_param_if.sv | 27 ++
 rtl/vending_fsm_param.sv | 152 +++++++++++++++
 tb/tb_vending_fsm_param.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vending_fsm_param_if.sv
// Coin-side / dispenser-side signal bundle for the vending controller.
// The master drives coins and cancel; the slave (controller) drives dispenser and hopper.
interface vending_fsm_param_if #(
  parameter int CW = 4
) ();
  logic          coin_a;
  logic          coin_b;
  logic          coin_c;
  logic          cancel;
  logic          dispense;
  logic          ret1;
  logic          ret2;
  logic          coin_reject;
  logic          busy;
  logic [CW-1:0] credit;
  logic [CW-1:0] change_total;

  modport master (
    output coin_a, coin_b, coin_c, cancel,
    input  dispense, ret1, ret2, coin_reject, busy, credit, change_total
  );

  modport slave (
    input  coin_a, coin_b, coin_c, cancel,
    output dispense, ret1, ret2, coin_reject, busy, credit, change_total
  );
endinterface

// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: accumulates coin credit, vends at PRICE and
// pays change or refunds as greedy 2/1-unit coin pulses. All outputs registered.
module vending_fsm_param #(
  parameter int PRICE    = 3,
  parameter int COIN_A   = 1,
  parameter int COIN_B   = 2,
  parameter int COIN_C   = 5,
  parameter int CW       = 4,
  parameter int DISP_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vending_fsm_param_if.slave   bus
);

  localparam int MAXC_AB = (COIN_A > COIN_B) ? COIN_A : COIN_B;
  localparam int MAXC    = (MAXC_AB > COIN_C) ? MAXC_AB : COIN_C;
  localparam int DCW     = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;

  localparam logic [CW-1:0]  VAL_A   = CW'(COIN_A);
  localparam logic [CW-1:0]  VAL_B   = CW'(COIN_B);
  localparam logic [CW-1:0]  VAL_C   = CW'(COIN_C);
  localparam logic [CW-1:0]  PRICE_V = CW'(PRICE);
  localparam logic [CW-1:0]  TWO     = CW'(2);
  localparam logic [CW-1:0]  ONE     = CW'(1);
  localparam logic [DCW-1:0] CNT_INI = DCW'(DISP_CYC - 1);

  if (PRICE < 1 || DISP_CYC < 1 || ((2 ** CW) - 1) < (PRICE - 1 + MAXC)) begin : g_bad_param
    $error("vending_fsm_param: illegal PRICE/DISP_CYC or CW too narrow for credit range");
  end

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  credit_q, credit_d;
  logic [CW-1:0]  ctot_q, ctot_d;
  logic [DCW-1:0] cnt_q, cnt_d;
  logic           disp_q, disp_d;
  logic           ret1_q, ret1_d;
  logic           ret2_q, ret2_d;
  logic           rej_q, rej_d;
  logic           busy_q, busy_d;

  logic           coin_any, coin_ok;
  logic [CW-1:0]  coin_val, newc, step_amt;

  assign coin_any = bus.coin_a | bus.coin_b | bus.coin_c;
  assign coin_ok  = $onehot({bus.coin_a, bus.coin_b, bus.coin_c});
  assign coin_val = bus.coin_a ? VAL_A : (bus.coin_b ? VAL_B : VAL_C);
  assign newc     = credit_q + coin_val;
  // Greedy change: a 2-unit coin whenever at least 2 units remain.
  assign step_amt = (credit_q >= TWO) ? TWO : ONE;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    ctot_d   = ctot_q;
    cnt_d    = cnt_q;
    disp_d   = 1'b0;
    ret1_d   = 1'b0;
    ret2_d   = 1'b0;
    rej_d    = 1'b0;
    case (state_q)
      IDLE, CREDIT: begin
        if (state_q == CREDIT && bus.cancel) begin
          // Refund starts on the same edge; a simultaneous coin is refused.
          rej_d    = coin_any;
          state_d  = CHANGE;
          ret2_d   = (step_amt == TWO);
          ret1_d   = (step_amt == ONE);
          credit_d = credit_q - step_amt;
          ctot_d   = ctot_q + step_amt;
        end else if (coin_any && !coin_ok) begin
          rej_d = 1'b1;
        end else if (coin_ok) begin
          ctot_d = '0;
          if (newc >= PRICE_V) begin
            credit_d = newc - PRICE_V;
            state_d  = VEND;
            disp_d   = 1'b1;
            cnt_d    = CNT_INI;
          end else begin
            credit_d = newc;
            state_d  = CREDIT;
          end
        end
      end
      VEND: begin
        rej_d = coin_any;
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - 1'b1;
          disp_d = 1'b1;
        end else if (credit_q != '0) begin
          // First change coin leaves together with the end of dispense.
          state_d  = CHANGE;
          ret2_d   = (step_amt == TWO);
          ret1_d   = (step_amt == ONE);
          credit_d = credit_q - step_amt;
          ctot_d   = ctot_q + step_amt;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        rej_d = coin_any;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else begin
          ret2_d   = (step_amt == TWO);
          ret1_d   = (step_amt == ONE);
          credit_d = credit_q - step_amt;
          ctot_d   = ctot_q + step_amt;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      ctot_q   <= '0;
      cnt_q    <= '0;
      disp_q   <= 1'b0;
      ret1_q   <= 1'b0;
      ret2_q   <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      ctot_q   <= ctot_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      ret1_q   <= ret1_d;
      ret2_q   <= ret2_d;
      rej_q    <= rej_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.dispense     = disp_q;
  assign bus.ret1         = ret1_q;
  assign bus.ret2         = ret2_q;
  assign bus.coin_reject  = rej_q;
  assign bus.busy         = busy_q;
  assign bus.credit       = credit_q;
  assign bus.change_total = ctot_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Bench for vending_fsm_param: default build plus a DISP_CYC=3 build share stimulus;
// per-cycle expected outputs are queued with the stimulus and checked after each edge.
module tb_vending_fsm_param;

  typedef struct packed {
    logic       disp;
    logic       r1;
    logic       r2;
    logic       rej;
    logic       busy;
    logic [3:0] cr;
    logic [3:0] ct;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  obs_t  exp_q[$];
  string tag_q[$];

  vending_fsm_param_if #(.CW(4)) bus0 ();
  vending_fsm_param_if #(.CW(4)) bus3 ();

  vending_fsm_param #(.PRICE(3), .COIN_A(1), .COIN_B(2), .COIN_C(5), .CW(4), .DISP_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  vending_fsm_param #(.PRICE(3), .COIN_A(1), .COIN_B(2), .COIN_C(5), .CW(4), .DISP_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic obs_t E(input logic d, input logic r1, input logic r2, input logic rej,
                             input logic busy, input int cr, input int ct);
    obs_t o;
    o.disp = d; o.r1 = r1; o.r2 = r2; o.rej = rej; o.busy = busy;
    o.cr = 4'(cr); o.ct = 4'(ct);
    return o;
  endfunction

  // Drive one cycle of stimulus, queue what must appear after the edge, then check it.
  task automatic step(input string tag, input logic rn, input logic a, input logic b,
                      input logic c, input logic cxl, input obs_t e);
    obs_t  got, exp;
    string t;
    rst_n = rn;
    bus0.coin_a = a; bus0.coin_b = b; bus0.coin_c = c; bus0.cancel = cxl;
    bus3.coin_a = a; bus3.coin_b = b; bus3.coin_c = c; bus3.cancel = cxl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (sel)
      got = '{bus3.dispense, bus3.ret1, bus3.ret2, bus3.coin_reject, bus3.busy,
              bus3.credit, bus3.change_total};
    else
      got = '{bus0.dispense, bus0.ret1, bus0.ret2, bus0.coin_reject, bus0.busy,
              bus0.credit, bus0.change_total};
    exp = exp_q.pop_front();
    t   = tag_q.pop_front();
    chk_eq({t, ".dispense"},     32'(got.disp), 32'(exp.disp));
    chk_eq({t, ".ret1"},         32'(got.r1),   32'(exp.r1));
    chk_eq({t, ".ret2"},         32'(got.r2),   32'(exp.r2));
    chk_eq({t, ".coin_reject"},  32'(got.rej),  32'(exp.rej));
    chk_eq({t, ".busy"},         32'(got.busy), 32'(exp.busy));
    chk_eq({t, ".credit"},       32'(got.cr),   32'(exp.cr));
    chk_eq({t, ".change_total"}, 32'(got.ct),   32'(exp.ct));
  endtask

  initial begin
    bus0.coin_a = 1'b0; bus0.coin_b = 1'b0; bus0.coin_c = 1'b0; bus0.cancel = 1'b0;
    bus3.coin_a = 1'b0; bus3.coin_b = 1'b0; bus3.coin_c = 1'b0; bus3.cancel = 1'b0;

    //        tag        rn a  b  c  cx  disp r1 r2 rej busy cr ct
    step("reset0",   0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
    step("reset1",   0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
    step("idle",     1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));

    // Three 1-unit coins: exact price, no change
    step("a3_1",     1, 1, 0, 0, 0, E(0, 0, 0, 0, 0, 1, 0));
    step("a3_2",     1, 1, 0, 0, 0, E(0, 0, 0, 0, 0, 2, 0));
    step("a3_3",     1, 1, 0, 0, 0, E(1, 0, 0, 0, 1, 0, 0));
    step("a3_end",   1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
    step("a3_idle",  1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));

    // Single 5-unit coin: vend then one 2-unit coin
    step("c_vend",   1, 0, 0, 1, 0, E(1, 0, 0, 0, 1, 2, 0));
    step("c_chg",    1, 0, 0, 0, 0, E(0, 0, 1, 0, 1, 0, 2));
    step("c_idle",   1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 2));

    // 2 then 5: change of 4 as two 2-unit coins
    step("bc_b",     1, 0, 1, 0, 0, E(0, 0, 0, 0, 0, 2, 0));
    step("bc_c",     1, 0, 0, 1, 0, E(1, 0, 0, 0, 1, 4, 0));
    step("bc_chg1",  1, 0, 0, 0, 0, E(0, 0, 1, 0, 1, 2, 2));
    step("bc_chg2",  1, 0, 0, 0, 0, E(0, 0, 1, 0, 1, 0, 4));
    step("bc_idle",  1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 4));

    // Cancel with a simultaneous coin: refund 2, coin refused; cancel in IDLE ignored
    step("cx_b",     1, 0, 1, 0, 0, E(0, 0, 0, 0, 0, 2, 0));
    step("cx_cxa",   1, 1, 0, 0, 1, E(0, 0, 1, 1, 1, 0, 2));
    step("cx_idle",  1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 2));
    step("cx_inidl", 1, 0, 0, 0, 1, E(0, 0, 0, 0, 0, 0, 2));

    // Multi-hot coin is refused, credit untouched
    step("mh_ab",    1, 1, 1, 0, 0, E(0, 0, 0, 1, 0, 0, 2));
    step("mh_idle",  1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 2));

    // 1 then 5: change 3 as 2 then 1; coins during VEND and CHANGE refused
    step("ac_a",     1, 1, 0, 0, 0, E(0, 0, 0, 0, 0, 1, 0));
    step("ac_c",     1, 0, 0, 1, 0, E(1, 0, 0, 0, 1, 3, 0));
    step("ac_chg2",  1, 1, 0, 0, 0, E(0, 0, 1, 1, 1, 1, 2));
    step("ac_chg1",  1, 0, 1, 0, 0, E(0, 1, 0, 1, 1, 0, 3));
    step("ac_idle",  1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 3));

    // Reset in the middle of paying change: everything cleared, then normal coin
    step("rs_b",     1, 0, 1, 0, 0, E(0, 0, 0, 0, 0, 2, 0));
    step("rs_c",     1, 0, 0, 1, 0, E(1, 0, 0, 0, 1, 4, 0));
    step("rs_chg",   1, 0, 0, 0, 0, E(0, 0, 1, 0, 1, 2, 2));
    step("rs_rst",   0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
    step("rs_a",     1, 1, 0, 0, 0, E(0, 0, 0, 0, 0, 1, 0));
    step("rs_cx",    1, 0, 0, 0, 1, E(0, 1, 0, 0, 1, 0, 1));
    step("rs_idle",  1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 1));

    // DISP_CYC=3 build: dispense exactly three cycles, coin during it refused
    step("d3_rst",   0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
    sel = 1'b1;
    step("d3_rst3",  0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
    step("d3_c",     1, 0, 0, 1, 0, E(1, 0, 0, 0, 1, 2, 0));
    step("d3_a",     1, 1, 0, 0, 0, E(1, 0, 0, 1, 1, 2, 0));
    step("d3_hold",  1, 0, 0, 0, 0, E(1, 0, 0, 0, 1, 2, 0));
    step("d3_chg",   1, 0, 0, 0, 0, E(0, 0, 1, 0, 1, 0, 2));
    step("d3_idle",  1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 2));

    if (exp_q.size() != 0) chk_eq("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
